// File: rtl/huff_stream_coder.sv
// ---------------------------------------------------------------------------
// huff_stream_coder
//   Streaming Huffman encoder. A code table (indexed directly by symbol value)
//   is loaded through a write port. Symbols arrive on a valid/ready stream; the
//   variable-length codes are packed MSB-first into WORD_W-bit words that leave
//   on a valid/ready stream. Each message ends with a final word (m_last) whose
//   m_bits field reports how many leading bits are meaningful.
//
// Handshake rule (both streams): a transfer happens on a rising clock edge
//   where valid && ready. A producer never drops valid, and never changes the
//   payload, until that transfer has happened.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   tbl_we/addr/code/len table write port (code right-aligned, LSB sent last)
//   s_valid/s_ready/s_symbol/s_last   symbol input stream
//   m_valid/m_ready/m_data/m_last/m_bits   packed word output stream
//   total_bits          code bits accumulated in the current message
//   busy                message in progress or bits pending
//   err                 sticky: [0] illegal code length, [1] table write while busy
//   dbg_state           current FSM state (ST_IN=0, ST_LOOK=1, ST_OUT=2, ST_FLUSH=3)
// ---------------------------------------------------------------------------
module huff_stream_coder #(
   parameter int SYM_W        = 8,
   parameter int MAX_CODE_LEN = 16,
   parameter int WORD_W       = 32,
   parameter int LEN_W        = 5,
   parameter int CNT_W        = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         tbl_we,
   input  logic [SYM_W-1:0]             tbl_addr,
   input  logic [MAX_CODE_LEN-1:0]      tbl_code,
   input  logic [LEN_W-1:0]             tbl_len,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [SYM_W-1:0]             s_symbol,
   input  logic                         s_last,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [WORD_W-1:0]            m_data,
   output logic                         m_last,
   output logic [$clog2(WORD_W+1)-1:0]  m_bits,
   output logic [CNT_W-1:0]             total_bits,
   output logic                         busy,
   output logic [1:0]                   err,
   output logic [1:0]                   dbg_state
);

   localparam int DEPTH  = 1 << SYM_W;
   localparam int ACC_W  = WORD_W + MAX_CODE_LEN;
   localparam int FILL_W = $clog2(ACC_W + 1);
   localparam int BITS_W = $clog2(WORD_W + 1);
   localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_CODE_LEN);
   localparam logic [FILL_W-1:0] WORD_F    = FILL_W'(WORD_W);

   typedef enum logic [1:0] {
      ST_IN    = 2'd0,
      ST_LOOK  = 2'd1,
      ST_OUT   = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // Code table; not cleared by reset.
   logic [MAX_CODE_LEN-1:0] r_tbl_code [DEPTH];
   logic [LEN_W-1:0]        r_tbl_len  [DEPTH];
   logic [MAX_CODE_LEN-1:0] r_rd_code;
   logic [LEN_W-1:0]        r_rd_len;

   // Accumulator is MSB-aligned: the oldest pending bit sits at ACC_W-1 and
   // everything below the fill count is kept zero, so padding comes for free.
   logic [ACC_W-1:0]  r_acc;
   logic [FILL_W-1:0] r_fill;
   logic              r_last_pend;
   logic              r_in_msg;    // a symbol of the current message was taken
   logic [CNT_W-1:0]  r_total;
   logic [1:0]        r_err;

   logic              w_s_ready;
   logic              w_m_valid;
   logic [WORD_W-1:0] w_m_data;
   logic              w_m_last;
   logic [BITS_W-1:0] w_m_bits;
   logic              w_busy;
   logic              w_hs_in;
   logic              w_tbl_wr;
   logic              w_len_ok;
   logic [LEN_W-1:0]  w_up;
   logic [ACC_W-1:0]  w_code_ext;
   logic [ACC_W-1:0]  w_align;
   logic [ACC_W-1:0]  w_ins;
   logic [FILL_W-1:0] w_fill_add;
   logic [FILL_W-1:0] w_fill_look;

   assign w_busy   = (r_state != ST_IN) || (r_fill != '0) || r_last_pend;
   assign w_hs_in  = s_valid && s_ready;
   assign w_tbl_wr = tbl_we && !w_busy && !reset;

   // Code alignment: place the code in the top MAX_CODE_LEN bits, slide it up
   // so its first bit lands at the MSB (this also discards any stale bits
   // above len), then slide it down below the bits already pending.
   assign w_len_ok    = (r_rd_len != '0) && (r_rd_len <= MAX_LEN_L);
   assign w_up        = MAX_LEN_L - r_rd_len;
   assign w_code_ext  = {r_rd_code, {WORD_W{1'b0}}};
   assign w_align     = w_code_ext << w_up;
   assign w_ins       = w_align >> r_fill;
   assign w_fill_add  = r_fill + FILL_W'(r_rd_len);
   assign w_fill_look = w_len_ok ? w_fill_add : r_fill;

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next state and stream outputs
   always_comb begin
      w_next_state = r_state;
      w_s_ready    = 1'b0;
      w_m_valid    = 1'b0;
      w_m_data     = '0;
      w_m_last     = 1'b0;
      w_m_bits     = '0;
      case (r_state)
         ST_IN: begin
            // Table writes take priority over symbol intake.
            w_s_ready = !tbl_we;
            if (s_valid && !tbl_we) begin
               w_next_state = ST_LOOK;
            end
         end
         ST_LOOK: begin
            if (w_fill_look >= WORD_F) begin
               w_next_state = ST_OUT;
            end else if (r_last_pend) begin
               w_next_state = ST_FLUSH;
            end else begin
               w_next_state = ST_IN;
            end
         end
         ST_OUT: begin
            w_m_valid = 1'b1;
            w_m_data  = r_acc[ACC_W-1 -: WORD_W];
            w_m_bits  = BITS_W'(WORD_W);
            // A message ending exactly on a word boundary needs no flush word.
            w_m_last  = r_last_pend && (r_fill == WORD_F);
            if (m_ready) begin
               if (w_m_last) begin
                  w_next_state = ST_IN;
               end else if (r_last_pend) begin
                  w_next_state = ST_FLUSH;
               end else begin
                  w_next_state = ST_IN;
               end
            end
         end
         ST_FLUSH: begin
            w_m_valid = 1'b1;
            w_m_last  = 1'b1;
            w_m_data  = r_acc[ACC_W-1 -: WORD_W];
            w_m_bits  = BITS_W'(r_fill);
            if (m_ready) begin
               w_next_state = ST_IN;
            end
         end
         default: begin
            w_next_state = ST_IN;
         end
      endcase
   end

   // Table storage and registered read
   always_ff @(posedge clock) begin
      if (w_tbl_wr) begin
         r_tbl_code[tbl_addr] <= tbl_code;
         r_tbl_len[tbl_addr]  <= tbl_len;
      end
      if (w_hs_in) begin
         r_rd_code <= r_tbl_code[s_symbol];
         r_rd_len  <= r_tbl_len[s_symbol];
      end
   end

   // Accumulator, message bookkeeping and error flags
   always_ff @(posedge clock) begin
      if (reset) begin
         r_acc       <= '0;
         r_fill      <= '0;
         r_last_pend <= 1'b0;
         r_in_msg    <= 1'b0;
         r_total     <= '0;
         r_err       <= '0;
      end else begin
         if (tbl_we && w_busy) begin
            r_err[1] <= 1'b1;
         end
         if (w_hs_in) begin
            r_last_pend <= s_last;
            r_in_msg    <= 1'b1;
            // First symbol of a new message restarts the bit count.
            if (!r_in_msg) begin
               r_total <= '0;
            end
         end
         case (r_state)
            ST_LOOK: begin
               if (w_len_ok) begin
                  r_acc   <= r_acc | w_ins;
                  r_fill  <= w_fill_add;
                  r_total <= r_total + CNT_W'(r_rd_len);
               end else begin
                  r_err[0] <= 1'b1;
               end
            end
            ST_OUT: begin
               if (m_ready) begin
                  r_acc  <= r_acc << WORD_W;
                  r_fill <= r_fill - WORD_F;
                  if (w_m_last) begin
                     r_last_pend <= 1'b0;
                     r_in_msg    <= 1'b0;
                  end
               end
            end
            ST_FLUSH: begin
               if (m_ready) begin
                  r_acc       <= '0;
                  r_fill      <= '0;
                  r_last_pend <= 1'b0;
                  r_in_msg    <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Intake is held off while reset is asserted.
   assign s_ready    = w_s_ready && !reset;
   assign m_valid    = w_m_valid;
   assign m_data     = w_m_data;
   assign m_last     = w_m_last;
   assign m_bits     = w_m_bits;
   assign total_bits = r_total;
   assign busy       = w_busy;
   assign err        = r_err;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_huff_stream_coder.sv
// ---------------------------------------------------------------------------
// tb_huff_stream_coder
//   Self-checking bench for huff_stream_coder. A reference model turns each
//   message into a list of code bits and chops it into expected output words;
//   a negedge monitor collects the words the DUT actually hands over.
// ---------------------------------------------------------------------------
module tb_huff_stream_coder;

   localparam int SYM_W  = 8;
   localparam int MAXL   = 16;
   localparam int WORD_W = 32;
   localparam int LEN_W  = 5;
   localparam int CNT_W  = 32;
   localparam int BITS_W = 6;
   localparam int EW     = WORD_W + BITS_W + 1;   // {data, bits, last}

   // ---------------- clock / reset / DUT ----------------
   logic                clock = 1'b0;
   logic                reset;
   logic                tbl_we;
   logic [SYM_W-1:0]    tbl_addr;
   logic [MAXL-1:0]     tbl_code;
   logic [LEN_W-1:0]    tbl_len;
   logic                s_valid;
   logic                s_ready;
   logic [SYM_W-1:0]    s_symbol;
   logic                s_last;
   logic                m_valid;
   logic                m_ready;
   logic [WORD_W-1:0]   m_data;
   logic                m_last;
   logic [BITS_W-1:0]   m_bits;
   logic [CNT_W-1:0]    total_bits;
   logic                busy;
   logic [1:0]          err;
   logic [1:0]          dbg_state;

   always #5 clock = ~clock;

   huff_stream_coder #(
      .SYM_W(SYM_W), .MAX_CODE_LEN(MAXL), .WORD_W(WORD_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_len(tbl_len),
      .s_valid(s_valid), .s_ready(s_ready), .s_symbol(s_symbol), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .m_bits(m_bits), .total_bits(total_bits), .busy(busy), .err(err),
      .dbg_state(dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int vectors    = 0;
   int miscompares = 0;

   // ---------------- reference model ----------------
   logic [MAXL-1:0]   mdl_code [256];
   logic [LEN_W-1:0]  mdl_len  [256];
   logic [SYM_W-1:0]  sym_q[$];
   logic [EW-1:0]     exp_q[$];
   logic [EW-1:0]     got_q[$];
   int unsigned       exp_total;
   logic [1:0]        exp_err = 2'b00;
   int                last_cnt = 0;
   int                ready_mode = 0;   // 0: always ready, 1: random, 2: held low
   logic [SYM_W-1:0]  we_addr = '0;

   // Build the message's bit string, then cut it into words.
   task automatic model_msg();
      bit bq[$];
      int n;
      int nb;
      logic [WORD_W-1:0] w;
      exp_q.delete();
      exp_total = 0;
      foreach (sym_q[i]) begin
         int l;
         l = int'(mdl_len[sym_q[i]]);
         if (l >= 1 && l <= MAXL) begin
            for (int k = l - 1; k >= 0; k--) bq.push_back(mdl_code[sym_q[i]][k]);
            exp_total += l;
         end else begin
            exp_err[0] = 1'b1;
         end
      end
      n = bq.size();
      if (n == 0) exp_q.push_back({{WORD_W{1'b0}}, 6'd0, 1'b1});
      for (int idx = 0; idx < n; idx += WORD_W) begin
         w = '0;
         for (int j = 0; j < WORD_W; j++)
            w = {w[WORD_W-2:0], (idx + j < n) ? bq[idx + j] : 1'b0};
         nb = (n - idx >= WORD_W) ? WORD_W : n - idx;
         exp_q.push_back({w, 6'(nb), (idx + WORD_W >= n)});
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      if (reset === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
         got_q.push_back({m_data, m_bits, m_last});
         if (m_last) last_cnt++;
      end
   end

   // ---------------- sink ready driver ----------------
   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = 1'b0;
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_entry(input logic [SYM_W-1:0] a, input logic [MAXL-1:0] c,
                             input logic [LEN_W-1:0] l);
      @(posedge clock); #1;
      tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
      @(posedge clock); #1;
      tbl_we = 1'b0;
      mdl_code[a] = c;
      mdl_len[a]  = l;
   endtask

   task automatic send_sym(input logic [SYM_W-1:0] s, input logic l, output bit ok);
      ok = 1'b0;
      @(posedge clock); #1;
      s_valid = 1'b1; s_symbol = s; s_last = l;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clock);
         if (s_ready === 1'b1) ok = 1'b1;
      end
      @(posedge clock); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   // Sends sym_q as one message and waits for its final word. When we_after
   // names a symbol index, a table write is attempted mid-message after it.
   task automatic drive_msg(input int we_after);
      bit ok;
      int start;
      int cyc;
      got_q.delete();
      start = last_cnt;
      for (int i = 0; i < sym_q.size(); i++) begin
         send_sym(sym_q[i], (i == sym_q.size() - 1), ok);
         if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: symbol %0d not accepted in 200 cycles", i);
            return;
         end
         if (i == we_after) begin
            repeat (3) @(posedge clock);
            #1;
            tbl_we = 1'b1; tbl_addr = we_addr; tbl_code = '0; tbl_len = 5'd7;
            @(posedge clock); #1;
            tbl_we = 1'b0;
         end
      end
      cyc = 0;
      while (last_cnt == start && cyc < 300) begin
         @(negedge clock);
         cyc++;
      end
      if (last_cnt == start) begin
         vectors++; miscompares++;
         $display("FAIL last_timeout: no m_last word within 300 cycles");
      end
      repeat (2) @(negedge clock);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      vectors += 8;
      if (s_ready !== 1'b0)    begin miscompares++; $display("FAIL rst_s_ready: got %b exp 0", s_ready); end
      if (m_valid !== 1'b0)    begin miscompares++; $display("FAIL rst_m_valid: got %b exp 0", m_valid); end
      if (m_data !== '0)       begin miscompares++; $display("FAIL rst_m_data: got %h exp 0", m_data); end
      if (m_last !== 1'b0)     begin miscompares++; $display("FAIL rst_m_last: got %b exp 0", m_last); end
      if (m_bits !== '0)       begin miscompares++; $display("FAIL rst_m_bits: got %0d exp 0", m_bits); end
      if (total_bits !== '0)   begin miscompares++; $display("FAIL rst_total: got %0d exp 0", total_bits); end
      if (busy !== 1'b0)       begin miscompares++; $display("FAIL rst_busy: got %b exp 0", busy); end
      if (err !== 2'b00)       begin miscompares++; $display("FAIL rst_err: got %b exp 00", err); end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [EW-1:0] g;
      load_entry(8'h41, 16'h0001, 5'd1);
      load_entry(8'h42, 16'h0001, 5'd2);
      load_entry(8'h43, 16'h0001, 5'd3);
      sym_q = '{8'h41, 8'h42, 8'h43};
      ready_mode = 0;
      model_msg();
      drive_msg(-1);
      vectors++;
      if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         vectors++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL basic_word%0d: exp %h", i, exp_q[i]); end
      end
      g = (got_q.size() > 0) ? got_q[0] : '0;
      vectors += 2;
      if (g !== {32'hA400_0000, 6'd6, 1'b1}) begin miscompares++; $display("FAIL basic_abs: got %h exp a4000000/6/1", g); end
      if (total_bits !== exp_total) begin miscompares++; $display("FAIL basic_total: got %0d exp %0d", total_bits, exp_total); end
   endtask

   task automatic test_full_words();
      load_entry(8'h10, 16'hFFFF, 5'd16);
      sym_q = '{8'h10, 8'h10, 8'h10, 8'h10};
      ready_mode = 0;
      model_msg();
      drive_msg(-1);
      vectors++;
      if (got_q.size() != 2) begin miscompares++; $display("FAIL full_count: got %0d exp 2", got_q.size()); end
      foreach (exp_q[i]) begin
         vectors++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL full_word%0d: exp %h", i, exp_q[i]); end
      end
      vectors++;
      if (total_bits !== 32'd64) begin miscompares++; $display("FAIL full_total: got %0d exp 64", total_bits); end
   endtask

   task automatic test_backpressure();
      logic [WORD_W-1:0] d0;
      int cyc;
      sym_q = '{8'h10, 8'h10, 8'h10, 8'h10};
      ready_mode = 2;
      model_msg();
      fork
         drive_msg(-1);
         begin
            cyc = 0;
            while (m_valid !== 1'b1 && cyc < 100) begin @(negedge clock); cyc++; end
            d0 = m_data;
            for (int k = 0; k < 10; k++) begin
               @(negedge clock);
               vectors += 3;
               if (m_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid%0d: got %b exp 1", k, m_valid); end
               if (m_data !== d0)    begin miscompares++; $display("FAIL bp_data%0d: got %h exp %h", k, m_data, d0); end
               if (s_ready !== 1'b0) begin miscompares++; $display("FAIL bp_s_ready%0d: got %b exp 0", k, s_ready); end
            end
            ready_mode = 0;
         end
      join
      vectors++;
      if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL bp_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         vectors++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_word%0d: exp %h", i, exp_q[i]); end
      end
   endtask

   task automatic test_illegal_len();
      load_entry(8'h00, 16'h1234, 5'd0);
      sym_q = '{8'h00};
      model_msg();
      drive_msg(-1);
      vectors += 2;
      if (err !== exp_err) begin miscompares++; $display("FAIL illegal_err: got %b exp %b", err, exp_err); end
      if (got_q.size() != 1) begin miscompares++; $display("FAIL illegal_count: got %0d exp 1", got_q.size()); end
      foreach (exp_q[i]) begin
         vectors++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL illegal_word%0d: exp %h", i, exp_q[i]); end
      end
   endtask

   task automatic test_table_write_busy();
      logic [EW-1:0] g;
      load_entry(8'h20, 16'h0005, 5'd3);
      load_entry(8'h21, 16'h0003, 5'd2);
      sym_q = '{8'h20, 8'h21};
      we_addr = 8'h20;
      model_msg();
      drive_msg(0);
      exp_err[1] = 1'b1;
      vectors++;
      if (err !== exp_err) begin miscompares++; $display("FAIL tblwr_err: got %b exp %b", err, exp_err); end
      foreach (exp_q[i]) begin
         vectors++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL tblwr_msg_word%0d: exp %h", i, exp_q[i]); end
      end
      sym_q = '{8'h20};
      model_msg();
      drive_msg(-1);
      g = (got_q.size() > 0) ? got_q[0] : '0;
      vectors += 2;
      if (got_q.size() != 1) begin miscompares++; $display("FAIL tblwr_count: got %0d exp 1", got_q.size()); end
      if (g !== {32'hA000_0000, 6'd3, 1'b1}) begin miscompares++; $display("FAIL tblwr_reencode: got %h exp a0000000/3/1", g); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      load_entry(8'h30, 16'h0015, 5'd5);
      for (int i = 0; i < 4; i++) begin
         send_sym(8'h30, 1'b0, ok);
         vectors++;
         if (!ok) begin miscompares++; $display("FAIL rstmid_send%0d: symbol not accepted", i); end
      end
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      exp_err = 2'b00;
      vectors += 4;
      if (m_valid !== 1'b0)  begin miscompares++; $display("FAIL rstmid_valid: got %b exp 0", m_valid); end
      if (busy !== 1'b0)     begin miscompares++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
      if (total_bits !== '0) begin miscompares++; $display("FAIL rstmid_total: got %0d exp 0", total_bits); end
      if (err !== exp_err)   begin miscompares++; $display("FAIL rstmid_err: got %b exp 00", err); end
      sym_q = '{8'h30, 8'h20, 8'h41};
      model_msg();
      drive_msg(-1);
      vectors += 2;
      if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rstmid_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
      if (total_bits !== exp_total) begin miscompares++; $display("FAIL rstmid_total2: got %0d exp %0d", total_bits, exp_total); end
      foreach (exp_q[i]) begin
         vectors++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rstmid_word%0d: exp %h", i, exp_q[i]); end
      end
   endtask

   task automatic test_random();
      int r;
      int nsym;
      logic [LEN_W-1:0] l;
      for (int m = 0; m < 12; m++) begin
         for (int e = 0; e < 8; e++) begin
            r = $urandom_range(0, 9);
            if (r == 0) l = ($urandom_range(0, 1) == 1) ? 5'd0 : LEN_W'($urandom_range(17, 31));
            else        l = LEN_W'($urandom_range(1, 16));
            load_entry(SYM_W'(8'h50 + e), MAXL'($urandom), l);
         end
         ready_mode = m % 2;
         sym_q.delete();
         nsym = $urandom_range(1, 12);
         for (int s = 0; s < nsym; s++) sym_q.push_back(SYM_W'(8'h50 + $urandom_range(0, 7)));
         model_msg();
         drive_msg(-1);
         vectors += 3;
         if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rnd%0d_count: got %0d exp %0d", m, got_q.size(), exp_q.size()); end
         if (total_bits !== exp_total) begin miscompares++; $display("FAIL rnd%0d_total: got %0d exp %0d", m, total_bits, exp_total); end
         if (err !== exp_err) begin miscompares++; $display("FAIL rnd%0d_err: got %b exp %b", m, err, exp_err); end
         foreach (exp_q[i]) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rnd%0d_word%0d: exp %h", m, i, exp_q[i]); end
         end
      end
      ready_mode = 0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- sequence / report ----------------
   initial begin
      reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0;
      s_valid = 1'b0; s_symbol = '0; s_last = 1'b0;
      test_reset();
      test_basic();
      test_full_words();
      test_backpressure();
      test_illegal_len();
      test_table_write_busy();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
